spi_cmd_sched: RTL and testbench

- Command scheduler in front of the SPI port-expander write path.
- Sequences the mandatory IODIR configuration write, then streams buffered GPIO data writes.
- Drives address/register/data plus a one-cycle send strobe to the SPI master, and tracks its idle line for acceptance and completion.
- Shares the single SPI master between the init requester and a data-write requester, with init priority.

---
 rtl/spi_sched_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/spi_cmd_sched.sv | 164 ++++++++++++++++
 tb/tb_spi_cmd_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types and default constants for the SPI command scheduler.
// Provides the FSM state enum, the command record handed to the SPI
// master, and the default device/register byte values.
package spi_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } sched_state_t;

  // Default bytes for the port expander
  localparam logic [7:0] DEF_DEV_ADDR  = 8'h40;
  localparam logic [7:0] DEF_REG_IODIR = 8'h00;
  localparam logic [7:0] DEF_REG_GPIO  = 8'h12;
  localparam logic [7:0] DEF_IODIR_VAL = 8'h00;

  // One SPI write command: device byte, register byte, data byte
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO buffering GPIO write data.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, data : write request and write data (ignored while full)
//   pop        : remove the head entry (ignored while empty)
//   full/empty : occupancy flags derived from the registered count
//   head       : oldest entry, valid while !empty
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage array needs no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_sched.sv
// Command scheduler in front of the SPI port-expander write path.
// Issues the IODIR configuration write (after reset or init_req), then
// streams buffered GPIO data writes, one at a time, to the SPI master.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   init_req          : pulse, request (re)configuration
//   wr_valid/wr_data  : GPIO write request and value
//   wr_ready          : buffer not full
//   spi_idle          : SPI master idle (1 = free / finished)
//   spi_address/register/data/send : command fields and start strobe
//   configured        : init write completed since last init request/reset
//   busy              : FSM not idle
//   timeout_err       : sticky, an SPI wait timed out
module spi_cmd_sched
  import spi_sched_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter logic [7:0] REG_IODIR   = DEF_REG_IODIR,
  parameter logic [7:0] REG_GPIO    = DEF_REG_GPIO,
  parameter logic [7:0] IODIR_VAL   = DEF_IODIR_VAL,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_req,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       spi_idle,
  output logic [7:0] spi_address,
  output logic [7:0] spi_register,
  output logic [7:0] spi_data,
  output logic       spi_send,
  output logic       configured,
  output logic       busy,
  output logic       timeout_err
);

  sched_state_t state, next_state;
  cmd_t         cmd;
  logic         cmd_is_init;
  logic         init_pend;
  logic [15:0]  tcnt;
  logic         tmo;
  logic         load_cmd;
  logic         sel_init;
  logic         done;
  logic         tmo_fire;
  logic         pop;
  logic         full;
  logic         empty;
  logic [7:0]   head;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .data  (wr_data),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign wr_ready = !full;
  assign tmo      = (tcnt == 16'(TIMEOUT_CYC - 1));

  // A finished or timed-out data command leaves the buffer either way
  assign pop = !cmd_is_init && (done || tmo_fire);

  // Next-state logic; init has priority over buffered data
  always_comb begin
    next_state = state;
    load_cmd   = 1'b0;
    sel_init   = 1'b0;
    done       = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (spi_idle && init_pend) begin
          next_state = S_ISSUE;
          load_cmd   = 1'b1;
          sel_init   = 1'b1;
        end else if (spi_idle && configured && !empty) begin
          next_state = S_ISSUE;
          load_cmd   = 1'b1;
        end
      end
      S_ISSUE: next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!spi_idle) begin
          next_state = S_WAIT_DONE;
        end else if (tmo) begin
          next_state = S_IDLE;
          tmo_fire   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (spi_idle) begin
          next_state = S_IDLE;
          done       = 1'b1;
        end else if (tmo) begin
          next_state = S_IDLE;
          tmo_fire   = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs: fields are held from ISSUE through WAIT_DONE, zero while idle
  always_comb begin
    spi_send     = (state == S_ISSUE);
    busy         = (state != S_IDLE);
    spi_address  = 8'h00;
    spi_register = 8'h00;
    spi_data     = 8'h00;
    if (state != S_IDLE) begin
      spi_address  = cmd.addr;
      spi_register = cmd.reg_addr;
      spi_data     = cmd.data;
    end
  end

  // State, command latch, wait counter and status flags.
  // init_req is applied last so it overrides a same-cycle init completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd         <= '0;
      cmd_is_init <= 1'b0;
      init_pend   <= 1'b1;
      configured  <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
    end else begin
      state <= next_state;
      if (load_cmd) begin
        cmd_is_init <= sel_init;
        if (sel_init)
          cmd <= '{addr: DEV_ADDR, reg_addr: REG_IODIR, data: IODIR_VAL};
        else
          cmd <= '{addr: DEV_ADDR, reg_addr: REG_GPIO, data: head};
      end
      // Counter restarts on entry to each wait state
      if (state == S_ISSUE || (state == S_WAIT_ACK && !spi_idle))
        tcnt <= '0;
      else if (state != S_IDLE)
        tcnt <= tcnt + 16'd1;
      if (done && cmd_is_init && !init_req) begin
        init_pend   <= 1'b0;
        configured  <= 1'b1;
        timeout_err <= 1'b0;
      end
      if (tmo_fire) timeout_err <= 1'b1;
      if (init_req) begin
        init_pend  <= 1'b1;
        configured <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Self-checking bench for spi_cmd_sched. Stimulus pushes the expected SPI
// commands into a queue; a monitor pops and compares on every spi_send.
// A small SPI master model drops idle one cycle after a send for three
// cycles, unless told to ignore sends (no_ack) or held busy (hold_busy).
module tb_spi_cmd_sched;

  localparam int TIMEOUT_CYC = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_req;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       spi_idle;
  logic [7:0] spi_address;
  logic [7:0] spi_register;
  logic [7:0] spi_data;
  logic       spi_send;
  logic       configured;
  logic       busy;
  logic       timeout_err;

  logic       model_idle = 1'b1;
  logic       hold_busy  = 1'b0;
  logic       no_ack     = 1'b0;

  int          total = 0;
  int          bad   = 0;
  logic [23:0] exp_q [$];
  logic [23:0] exp_cmd;

  localparam logic [23:0] CMD_INIT = 24'h40_00_00;

  always #5 clk = ~clk;

  assign spi_idle = model_idle & ~hold_busy;

  spi_cmd_sched #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .init_req     (init_req),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .spi_idle     (spi_idle),
    .spi_address  (spi_address),
    .spi_register (spi_register),
    .spi_data     (spi_data),
    .spi_send     (spi_send),
    .configured   (configured),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Ends on the negedge of the send cycle; expiry counts as a failure
  task automatic waitSend(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (spi_send !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (spi_send !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: no spi_send within %0d cycles", name, limit);
    end
  endtask

  task automatic waitIdle(input string name, input logic lvl, input int limit);
    int n = 0;
    @(negedge clk);
    while (spi_idle !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (spi_idle !== lvl) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: spi_idle never reached %0b", name, lvl);
    end
  endtask

  task automatic waitConfigured(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (configured !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, configured, 1);
  endtask

  // SPI master model
  initial begin
    forever begin
      @(negedge clk);
      if (spi_send === 1'b1 && !no_ack) begin
        @(posedge clk);
        #2 model_idle = 1'b0;
        repeat (3) @(posedge clk);
        #2 model_idle = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (spi_send === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_send: got %h%h%h expected none",
                 spi_address, spi_register, spi_data);
      end else begin
        exp_cmd = exp_q.pop_front();
        checkOutput("send_cmd", {8'h00, spi_address, spi_register, spi_data}, {8'h00, exp_cmd});
      end
      if (spi_register == 8'h12) checkOutput("gpio_needs_cfg", configured, 1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] vals [5];
    int n;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1; init_req = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_send", spi_send, 0);
    checkOutput("rst_fields", {spi_address, spi_register, spi_data}, 0);
    checkOutput("rst_configured", configured, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);

    // Automatic init after reset, one-cycle issue latency
    exp_q.push_back(CMD_INIT);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("send_before_latency", spi_send, 0);
    @(negedge clk);
    checkOutput("first_send_latency", spi_send, 1);

    // Data pushed before configured waits for init to finish
    exp_q.push_back(24'h40_12_A5);
    tick();
    applyStimulus(8'hA5);
    waitIdle("init_ack", 1'b0, 20);
    waitIdle("init_done", 1'b1, 20);
    checkOutput("cfg_at_idle_rise", configured, 0);
    @(negedge clk);
    checkOutput("cfg_after_idle_rise", configured, 1);
    repeat (15) @(negedge clk);
    checkOutput("a5_drained", exp_q.size(), 0);

    // Fill buffer while the master is busy; fifth push dropped
    tick();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vals[i]);
      @(negedge clk);
      checkOutput("wr_ready_fill", wr_ready, (i < 3) ? 1 : 0);
      if (i < 4) exp_q.push_back({16'h40_12, vals[i]});
    end
    tick();
    hold_busy = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("fill_drained", exp_q.size(), 0);
    checkOutput("fill_wr_ready", wr_ready, 1);

    // init_req during a data WAIT_DONE: that write finishes, init jumps ahead
    tick();
    hold_busy = 1'b1;
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    exp_q.push_back(24'h40_12_66);
    exp_q.push_back(CMD_INIT);
    exp_q.push_back(24'h40_12_77);
    tick();
    hold_busy = 1'b0;
    waitSend("t4_send", 50);
    tick();
    tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    @(negedge clk);
    checkOutput("reinit_cfg_cleared", configured, 0);
    waitConfigured("reinit_cfg_set", 60);
    repeat (30) @(negedge clk);
    checkOutput("reinit_drained", exp_q.size(), 0);

    // Data command with no ack: timeout, dropped
    tick();
    no_ack = 1'b1;
    exp_q.push_back(24'h40_12_88);
    applyStimulus(8'h88);
    waitSend("t5_send", 50);
    n = 0;
    while (timeout_err !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_latency", n, TIMEOUT_CYC + 1);
    repeat (10) @(negedge clk);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_dropped", exp_q.size(), 0);
    checkOutput("timeout_cfg_kept", configured, 1);

    // Init with no ack retries; success clears timeout_err
    exp_q.push_back(CMD_INIT);
    tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    waitSend("init_try1", 50);
    tick();
    no_ack = 1'b0;
    exp_q.push_back(CMD_INIT);
    waitSend("init_retry", 2000);
    checkOutput("timeout_sticky", timeout_err, 1);
    waitConfigured("retry_cfg", 30);
    checkOutput("timeout_cleared", timeout_err, 0);
    repeat (5) @(negedge clk);

    // Reset during WAIT_DONE
    tick();
    exp_q.push_back(24'h40_12_99);
    applyStimulus(8'h99);
    waitSend("t6_send", 50);
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_send", spi_send, 0);
    checkOutput("midrst_fields", {spi_address, spi_register, spi_data}, 0);
    checkOutput("midrst_cfg", configured, 0);
    checkOutput("midrst_wr_ready", wr_ready, 1);
    exp_q.push_back(CMD_INIT);
    tick();
    rst = 1'b0;
    waitSend("t6_init", 50);
    waitConfigured("t6_cfg", 30);
    repeat (20) @(negedge clk);
    checkOutput("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
